// File: rtl/select_best_hop_pkg.sv
// Shared constants, table layout and state encoding for the best-hop scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package select_best_hop_pkg;

    localparam int WORD_WIDTH = 16;

    // Codes shared with the downstream action-selection stage
    localparam logic [WORD_WIDTH-1:0] SELF_CODE = 16'd300;
    localparam logic [WORD_WIDTH-1:0] NO_SINK   = 16'd65;

    // Neighbour entry layout: four consecutive words per entry
    localparam logic [WORD_WIDTH-1:0] OFF_ID      = 16'd0;
    localparam logic [WORD_WIDTH-1:0] OFF_Q       = 16'd1;
    localparam logic [WORD_WIDTH-1:0] OFF_CL      = 16'd2;
    localparam logic [WORD_WIDTH-1:0] OFF_FL      = 16'd3;
    localparam logic [WORD_WIDTH-1:0] ENTRY_WORDS = 16'd4;
    // The count word sits in front of entry 0
    localparam logic [WORD_WIDTH-1:0] COUNT_WORDS = 16'd1;

    localparam int SINK_BIT = 0;

    typedef enum logic [3:0] {
        WAIT_EN  = 4'd0,
        IDLE     = 4'd1,
        C_ADDR   = 4'd2,
        C_LATCH  = 4'd3,
        ID_ADDR  = 4'd4,
        ID_LATCH = 4'd5,
        Q_ADDR   = 4'd6,
        Q_LATCH  = 4'd7,
        CL_ADDR  = 4'd8,
        CL_LATCH = 4'd9,
        FL_ADDR  = 4'd10,
        FL_LATCH = 4'd11,
        DONE     = 4'd12
    } state_t;

endpackage

// File: rtl/select_best_hop.sv
// Scans the neighbour table in memory, picks the best-Q next hop and first in-cluster sink.
// Latency: done rises 3 + 8*N_eff clock edges after start is sampled in IDLE.
// Backpressure: none; memory answers in a fixed 1 cycle, the round is paced by en/start/done.
module select_best_hop
    import select_best_hop_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] TABLE_BASE    = 16'h010,
    parameter int                    MAX_NEIGHBORS = 16
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] mem_data_in,
    input  logic [WORD_WIDTH-1:0] my_q,
    input  logic [WORD_WIDTH-1:0] my_cluster_id,
    output logic [WORD_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] nexthop,
    output logic [WORD_WIDTH-1:0] nextsinks,
    output logic                  done
);

    localparam logic [WORD_WIDTH-1:0] MAX_N = WORD_WIDTH'(MAX_NEIGHBORS);

    state_t state, state_nxt;

    // Scan bookkeeping
    logic [WORD_WIDTH-1:0] entry_base, entry_base_nxt;
    logic [WORD_WIDTH-1:0] remaining, remaining_nxt;
    logic [WORD_WIDTH-1:0] cur_id, cur_id_nxt;
    logic [WORD_WIDTH-1:0] cur_q, cur_q_nxt;
    logic [WORD_WIDTH-1:0] cur_cl, cur_cl_nxt;
    logic [WORD_WIDTH-1:0] best_q, best_q_nxt;
    logic [WORD_WIDTH-1:0] best_id, best_id_nxt;
    logic [WORD_WIDTH-1:0] sink_id, sink_id_nxt;
    logic                  sink_found, sink_found_nxt;

    logic [WORD_WIDTH-1:0] address_nxt;
    logic [WORD_WIDTH-1:0] nexthop_nxt;
    logic [WORD_WIDTH-1:0] nextsinks_nxt;
    logic                  done_nxt;

    logic [WORD_WIDTH-1:0] eff_count;
    logic                  last_entry;
    logic                  better_q;
    logic                  sink_hit;

    // Count clamp is only meaningful in C_LATCH, where mem_data_in holds the count word
    assign eff_count  = (mem_data_in > MAX_N) ? MAX_N : mem_data_in;
    assign last_entry = (remaining == COUNT_WORDS);
    // Strict compare so ties keep the earlier entry and my_q itself never loses to an equal Q
    assign better_q   = (cur_q > best_q);
    // Only the first matching sink counts; mem_data_in holds the flags word in FL_LATCH
    assign sink_hit   = !sink_found && mem_data_in[SINK_BIT] && (cur_cl == my_cluster_id);

    // State register
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state <= WAIT_EN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one ADDR/LATCH pair per word, four words per entry
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_EN:  if (en) state_nxt = IDLE;
            IDLE:     if (start) state_nxt = C_ADDR;
            C_ADDR:   state_nxt = C_LATCH;
            C_LATCH:  state_nxt = (eff_count == '0) ? DONE : ID_ADDR;
            ID_ADDR:  state_nxt = ID_LATCH;
            ID_LATCH: state_nxt = Q_ADDR;
            Q_ADDR:   state_nxt = Q_LATCH;
            Q_LATCH:  state_nxt = CL_ADDR;
            CL_ADDR:  state_nxt = CL_LATCH;
            CL_LATCH: state_nxt = FL_ADDR;
            FL_ADDR:  state_nxt = FL_LATCH;
            FL_LATCH: state_nxt = last_entry ? DONE : ID_ADDR;
            DONE:     state_nxt = WAIT_EN;
            default:  state_nxt = WAIT_EN;
        endcase
    end

    // Output/datapath logic: next values of every register, keyed on the current state
    always_comb begin
        address_nxt    = address;
        nexthop_nxt    = nexthop;
        nextsinks_nxt  = nextsinks;
        done_nxt       = done;
        entry_base_nxt = entry_base;
        remaining_nxt  = remaining;
        cur_id_nxt     = cur_id;
        cur_q_nxt      = cur_q;
        cur_cl_nxt     = cur_cl;
        best_q_nxt     = best_q;
        best_id_nxt    = best_id;
        sink_id_nxt    = sink_id;
        sink_found_nxt = sink_found;
        unique case (state)
            WAIT_EN: begin
                if (en) done_nxt = 1'b0;
            end
            IDLE: begin
                if (start) address_nxt = TABLE_BASE;
            end
            C_LATCH: begin
                remaining_nxt  = eff_count;
                best_q_nxt     = my_q;
                best_id_nxt    = SELF_CODE;
                sink_id_nxt    = NO_SINK;
                sink_found_nxt = 1'b0;
                entry_base_nxt = TABLE_BASE + COUNT_WORDS;
                if (eff_count != '0) address_nxt = TABLE_BASE + COUNT_WORDS + OFF_ID;
            end
            ID_LATCH: begin
                cur_id_nxt  = mem_data_in;
                address_nxt = entry_base + OFF_Q;
            end
            Q_LATCH: begin
                cur_q_nxt   = mem_data_in;
                address_nxt = entry_base + OFF_CL;
            end
            CL_LATCH: begin
                cur_cl_nxt  = mem_data_in;
                address_nxt = entry_base + OFF_FL;
            end
            FL_LATCH: begin
                if (better_q) begin
                    best_q_nxt  = cur_q;
                    best_id_nxt = cur_id;
                end
                if (sink_hit) begin
                    sink_id_nxt    = cur_id;
                    sink_found_nxt = 1'b1;
                end
                if (!last_entry) begin
                    remaining_nxt  = remaining - COUNT_WORDS;
                    entry_base_nxt = entry_base + ENTRY_WORDS;
                    address_nxt    = entry_base + ENTRY_WORDS + OFF_ID;
                end
            end
            DONE: begin
                nexthop_nxt   = best_id;
                nextsinks_nxt = sink_id;
                done_nxt      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial scan
    always_ff @(posedge clock) begin
        if (!nrst) begin
            address    <= '0;
            nexthop    <= SELF_CODE;
            nextsinks  <= NO_SINK;
            done       <= 1'b0;
            entry_base <= '0;
            remaining  <= '0;
            cur_id     <= '0;
            cur_q      <= '0;
            cur_cl     <= '0;
            best_q     <= '0;
            best_id    <= '0;
            sink_id    <= '0;
            sink_found <= 1'b0;
        end else begin
            address    <= address_nxt;
            nexthop    <= nexthop_nxt;
            nextsinks  <= nextsinks_nxt;
            done       <= done_nxt;
            entry_base <= entry_base_nxt;
            remaining  <= remaining_nxt;
            cur_id     <= cur_id_nxt;
            cur_q      <= cur_q_nxt;
            cur_cl     <= cur_cl_nxt;
            best_q     <= best_q_nxt;
            best_id    <= best_id_nxt;
            sink_id    <= sink_id_nxt;
            sink_found <= sink_found_nxt;
        end
    end

endmodule
